// File: rtl/ram8_arbiter_if.sv
// Request/bank bundle for ram8_arbiter.
// The slave modport is the arbiter's view. The master modport is the environment's view:
// the requesters plus the register bank, which supplies ram_out.
interface ram8_arbiter_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
);
  logic [3:0]          req;
  logic [3:0]          we;
  logic [4*ADDR_W-1:0] addr;
  logic [4*DATA_W-1:0] wdata;
  logic [DATA_W-1:0]   ram_out;
  logic [ADDR_W-1:0]   ram_sel;
  logic                ram_load;
  logic [DATA_W-1:0]   ram_in;
  logic [3:0]          ack;
  logic [DATA_W-1:0]   rdata;
  logic                busy;

  modport slave (
    input  req, we, addr, wdata, ram_out,
    output ram_sel, ram_load, ram_in, ack, rdata, busy
  );

  modport master (
    output req, we, addr, wdata, ram_out,
    input  ram_sel, ram_load, ram_in, ack, rdata, busy
  );
endinterface

// File: rtl/ram8_arbiter.sv
// Four-port arbiter and access sequencer for an 8 x DATA_W register bank.
// Each grant takes three cycles: IDLE (sample and grant), ACCESS (bank lines driven),
// and DONE (one-cycle ack to the winner).
// Macro RAM8_ARB_RR_EN: when defined, round-robin arbitration over a last-winner pointer.
// When undefined, fixed priority with requester 0 highest.
module ram8_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  ram8_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e              r_state, w_state_nxt;
  logic [1:0]          r_win, w_win_nxt;
  logic [ADDR_W-1:0]   r_ram_sel, w_ram_sel_nxt;
  logic                r_ram_load, w_ram_load_nxt;
  logic [DATA_W-1:0]   r_ram_in, w_ram_in_nxt;
  logic [3:0]          r_ack, w_ack_nxt;
  logic [DATA_W-1:0]   r_rdata, w_rdata_nxt;
  logic                r_busy, w_busy_nxt;

  logic                w_any;
  logic [1:0]          w_pick;

`ifdef RAM8_ARB_RR_EN
  logic [1:0]          r_last, w_last_nxt;
  logic [1:0]          w_idx;

  // Round-robin pick: search last+1 .. last+4. The loop runs backwards so the
  // earliest position in the search order overwrites the later ones.
  always_comb begin
    w_any  = |bus.req;
    w_pick = '0;
    w_idx  = '0;
    for (int k = 3; k >= 0; k--) begin
      w_idx = r_last + 2'(k + 1);
      if (bus.req[w_idx]) w_pick = w_idx;
    end
  end
`else
  // Fixed-priority pick: the lowest requester index wins.
  always_comb begin
    w_any  = |bus.req;
    w_pick = '0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req[k]) w_pick = 2'(k);
    end
  end
`endif

  // Next-state logic and next values for all registered outputs.
  always_comb begin
    w_state_nxt    = r_state;
    w_win_nxt      = r_win;
    w_ram_sel_nxt  = r_ram_sel;
    w_ram_load_nxt = r_ram_load;
    w_ram_in_nxt   = r_ram_in;
    w_ack_nxt      = '0;
    w_rdata_nxt    = r_rdata;
    w_busy_nxt     = r_busy;
`ifdef RAM8_ARB_RR_EN
    w_last_nxt     = r_last;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_any) begin
          w_win_nxt      = w_pick;
          w_ram_sel_nxt  = bus.addr[int'(w_pick) * ADDR_W +: ADDR_W];
          w_ram_in_nxt   = bus.wdata[int'(w_pick) * DATA_W +: DATA_W];
          w_ram_load_nxt = bus.we[w_pick];
          w_busy_nxt     = 1'b1;
          w_state_nxt    = StAccess;
`ifdef RAM8_ARB_RR_EN
          w_last_nxt     = w_pick;
`endif
        end
      end
      StAccess: begin
        // ram_load still holds the winner's we, so it tells a read from a write.
        if (!r_ram_load) w_rdata_nxt = bus.ram_out;
        w_ram_load_nxt = 1'b0;
        w_ack_nxt      = 4'b0001 << r_win;
        w_state_nxt    = StDone;
      end
      StDone: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = StIdle;
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // State and output registers. Reset drops ram_load at once, which aborts a write in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_win      <= '0;
      r_ram_sel  <= '0;
      r_ram_load <= 1'b0;
      r_ram_in   <= '0;
      r_ack      <= '0;
      r_rdata    <= '0;
      r_busy     <= 1'b0;
`ifdef RAM8_ARB_RR_EN
      r_last     <= 2'd3;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_win      <= w_win_nxt;
      r_ram_sel  <= w_ram_sel_nxt;
      r_ram_load <= w_ram_load_nxt;
      r_ram_in   <= w_ram_in_nxt;
      r_ack      <= w_ack_nxt;
      r_rdata    <= w_rdata_nxt;
      r_busy     <= w_busy_nxt;
`ifdef RAM8_ARB_RR_EN
      r_last     <= w_last_nxt;
`endif
    end
  end

  assign bus.ram_sel  = r_ram_sel;
  assign bus.ram_load = r_ram_load;
  assign bus.ram_in   = r_ram_in;
  assign bus.ack      = r_ack;
  assign bus.rdata    = r_rdata;
  assign bus.busy     = r_busy;

endmodule

// File: tb/tb_ram8_arbiter.sv
// Scoreboard bench for ram8_arbiter.
// The bench contains the 8-word register bank. A transaction-level model predicts each grant,
// its ACCESS cycle and the ack/rdata it produces. A negedge monitor compares the DUT's outputs
// against the queued predictions.
module tb_ram8_arbiter;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram8_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  ram8_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Register bank: demux load into eight registers, combinational read mux.
  logic [DATA_W-1:0] bank [8];
  always @(posedge clk) if (bus.ram_load) bank[bus.ram_sel] <= bus.ram_in;
  assign bus.ram_out = bank[bus.ram_sel];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int               acc;   // cycle in which the bank lines carry this access
    int               win;
    bit               we;
    logic [2:0]       addr;
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] rd;   // rdata expected in the ack cycle
  } exp_t;

  exp_t              sb[$];
  int                ack_log[$];
  logic [DATA_W-1:0] mem [8];
  int                free_c;
  int                m_last;
  logic [DATA_W-1:0] last_rd;
  bit                pend;
  int                pend_acc;
  logic [2:0]        pend_a;
  logic [DATA_W-1:0] pend_d;
  int                m_w;
  int                m_j;
  exp_t              m_e;

  // A grant occupies three cycles. The model grants when the arbiter is free and some req is
  // high, and commits a write to its memory once the ACCESS cycle has closed.
  always @(negedge clk) begin
    if (pend && cyc > pend_acc) begin
      mem[pend_a] = pend_d;
      pend = 1'b0;
    end
    if (!rst_n) begin
      sb.delete();
      free_c  = 0;
      m_last  = 3;
      last_rd = '0;
      pend    = 1'b0;
    end else if (cyc >= free_c && bus.req != 4'b0) begin
      m_w = -1;
`ifdef RAM8_ARB_RR_EN
      for (int k = 1; k <= 4; k++) begin
        m_j = (m_last + k) % 4;
        if (m_w < 0 && bus.req[m_j]) m_w = m_j;
      end
`else
      for (int k = 0; k < 4; k++) begin
        if (m_w < 0 && bus.req[k]) m_w = k;
      end
`endif
      m_e.acc  = cyc + 1;
      m_e.win  = m_w;
      m_e.we   = bus.we[m_w];
      m_e.addr = bus.addr[m_w*ADDR_W +: ADDR_W];
      m_e.data = bus.wdata[m_w*DATA_W +: DATA_W];
      if (m_e.we) begin
        pend     = 1'b1;
        pend_acc = m_e.acc;
        pend_a   = m_e.addr;
        pend_d   = m_e.data;
      end else begin
        last_rd = mem[m_e.addr];
      end
      m_e.rd = last_rd;
      sb.push_back(m_e);
      free_c = cyc + 3;
      m_last = m_w;
    end
  end

  // ---------------- monitor ----------------
  bit mon_acc;
  bit mon_done;
  always @(negedge clk) begin
    if (rst_n) begin
      mon_acc  = 1'b0;
      mon_done = 1'b0;
      if (sb.size() > 0 && sb[0].acc + 1 < cyc) begin
        checks++;
        errors++;
        $display("FAIL ack_missing: no ack for requester %0d, want it in cycle %0d (now %0d)",
                 sb[0].win, sb[0].acc + 1, cyc);
        void'(sb.pop_front());
      end
      if (sb.size() > 0) begin
        mon_acc  = (sb[0].acc == cyc);
        mon_done = (sb[0].acc + 1 == cyc);
      end
      if (mon_acc) begin
        chk("ram_load", 32'(bus.ram_load), 32'(sb[0].we));
        chk("ram_sel", 32'(bus.ram_sel), 32'(sb[0].addr));
        if (sb[0].we) chk("ram_in", 32'(bus.ram_in), 32'(sb[0].data));
      end else begin
        chk("ram_load_idle", 32'(bus.ram_load), 32'd0);
      end
      if (mon_done) begin
        chk("ack", 32'(bus.ack), 32'(4'b0001 << sb[0].win));
        chk("rdata", 32'(bus.rdata), 32'(sb[0].rd));
        ack_log.push_back(sb[0].win);
        void'(sb.pop_front());
      end else begin
        chk("ack_idle", 32'(bus.ack), 32'd0);
      end
      chk("busy", 32'(bus.busy), 32'(mon_acc || mon_done));
    end
  end

  // ---------------- requester driver ----------------
  logic [3:0] rearm;
  logic [3:0] ack_seen;

  // One clock. A requester whose ack was high drops req after the edge, unless it is re-arming.
  task automatic tick();
    @(negedge clk);
    ack_seen = bus.ack;
    @(posedge clk);
    #1;
    bus.req = bus.req & ~(ack_seen & ~rearm);
  endtask

  task automatic issue(input int i, input bit w, input int a, input logic [DATA_W-1:0] d);
    bus.we[i]                    = w;
    bus.addr[i*ADDR_W +: ADDR_W] = 3'(a);
    bus.wdata[i*DATA_W +: DATA_W] = d;
    bus.req[i]                   = 1'b1;
  endtask

  task automatic drain();
    for (int n = 0; n < 40; n++) begin
      if (bus.req == 4'b0 && sb.size() == 0) break;
      tick();
    end
    chk("drain_done", 32'(bus.req == 4'b0 && sb.size() == 0), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_load"}, 32'(bus.ram_load), 32'd0);
    chk({tag, "_sel"}, 32'(bus.ram_sel), 32'd0);
    chk({tag, "_in"}, 32'(bus.ram_in), 32'd0);
    chk({tag, "_ack"}, 32'(bus.ack), 32'd0);
    chk({tag, "_rdata"}, 32'(bus.rdata), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_log;

  initial begin
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    rearm = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("rst");
    rst_n = 1'b1;

    // Idle: the monitor expects busy = 0 and ack = 0 on every one of these cycles.
    repeat (10) tick();

    // Requester 2 writes BEEF to address 5, then reads it back.
    issue(2, 1'b1, 5, 16'hBEEF);
    tick();
    chk("beef_sel", 32'(bus.ram_sel), 32'd5);
    chk("beef_load", 32'(bus.ram_load), 32'd1);
    tick();
    chk("beef_ack", 32'(bus.ack), 32'(4'b0100));
    chk("beef_load_off", 32'(bus.ram_load), 32'd0);
    drain();
    issue(2, 1'b0, 5, 16'h0);
    tick();
    tick();
    chk("beef_rdata", 32'(bus.rdata), 32'hBEEF);
    drain();

    // Write all eight words from rotating requesters. rdata must keep the BEEF read value.
    for (int a = 0; a < 8; a++) begin
      issue(a % 4, 1'b1, a, 16'h1000 + 16'(a));
      drain();
    end
    chk("rdata_held", 32'(bus.rdata), 32'hBEEF);
    for (int a = 0; a < 8; a++) begin
      issue((a + 1) % 4, 1'b0, a, 16'h0);
      drain();
      chk("readback", 32'(bus.rdata), 32'h1000 + 32'(a));
    end

    // Reset in the middle of a write ACCESS cycle aborts the write.
    issue(1, 1'b1, 6, 16'hDEAD);
    tick();
    chk("abort_pre_load", 32'(bus.ram_load), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("abort");
    bus.req = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("abort_word", 32'(bank[6]), 32'h1006);

    ack_log.delete();
`ifdef RAM8_ARB_RR_EN
    // All four requesters keep requesting. Grants rotate starting at requester 0.
    rearm = 4'hF;
    for (int i = 0; i < 4; i++) issue(i, 1'b0, i, 16'h0);
    repeat (15) tick();
    rearm = '0;
    drain();
    n_log = ack_log.size();
    chk("rr_count", 32'(n_log >= 5), 32'd1);
    if (n_log >= 5) begin
      for (int k = 0; k < 5; k++) chk("rr_order", 32'(ack_log[k]), 32'(k % 4));
    end
`else
    // Requesters 1 and 3 both request. Requester 1 wins until it stops re-arming.
    rearm = 4'b0010;
    issue(1, 1'b0, 1, 16'h0);
    issue(3, 1'b0, 3, 16'h0);
    repeat (9) tick();
    rearm = '0;
    drain();
    n_log = ack_log.size();
    chk("fp_count", 32'(n_log >= 4), 32'd1);
    if (n_log >= 4) begin
      for (int k = 0; k < n_log - 1; k++) chk("fp_first", 32'(ack_log[k]), 32'd1);
      chk("fp_last", 32'(ack_log[n_log-1]), 32'd3);
    end
`endif

    // The aborted write left address 6 holding its earlier value.
    issue(0, 1'b0, 6, 16'h0);
    drain();
    chk("abort_readback", 32'(bus.rdata), 32'h1006);

    // A request raised during ACCESS waits for the next IDLE.
    issue(0, 1'b0, 2, 16'h0);
    tick();
    issue(3, 1'b0, 3, 16'h0);
    tick();
    chk("busy_ack0", 32'(bus.ack), 32'(4'b0001));
    tick();
    chk("busy_idle", 32'(bus.busy), 32'd0);
    tick();
    tick();
    chk("busy_ack3", 32'(bus.ack), 32'(4'b1000));
    chk("busy_rd3", 32'(bus.rdata), 32'h1003);
    drain();

    // Random traffic: idle requesters pick up new random requests.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (!bus.req[i] && $urandom_range(0, 2) == 0)
          issue(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 16'($urandom));
      end
      tick();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
